stage_sequencer: RTL and testbench

- Parametrised multi-cycle stage controller for the core, replacing the fixed seven-stage fsm.
- Steps a one-hot stage vector through CONTROL, FETCH, DECODE, intermediate stages and WRITE_BACK.
- Skips stages marked unused by decode and maps faults to trap causes.
- Injects interrupt/trap sequences, supports debug halt, flags double faults, and keeps cycle and retired-instruction counters.

---
 rtl/stage_sequencer.sv | 175 +++++++++++++++++
 tb/tb_stage_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer: walks a one-hot stage vector, skips unused stages,
// maps faults to trap causes, handles interrupt/trap entry, debug halt and counters.
module stage_sequencer #(
  parameter int NUM_STAGES   = 7,
  parameter int FETCH_STAGE  = 1,
  parameter int DECODE_STAGE = 2,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_STAGES-1:0] stage_done,
  input  logic [NUM_STAGES-1:0] stage_skip,
  input  logic                  op_fault,
  input  logic                  addr_fault,
  input  logic                  access_fault,
  input  logic                  is_store,
  input  logic                  ext_int_pending,
  input  logic                  sw_int_pending,
  input  logic                  halt_req,
  output logic [NUM_STAGES-1:0] stage_active,
  output logic [1:0]            control_op,
  output logic [2:0]            fault_num,
  output logic                  halted,
  output logic                  double_fault,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      retired_count
);

  localparam logic [1:0] OP_TRAP = 2'b00;
  localparam logic [1:0] OP_EXT  = 2'b01;
  localparam logic [1:0] OP_SW   = 2'b10;
  localparam logic [1:0] OP_NORM = 2'b11;

  localparam logic [NUM_STAGES-1:0] CTRL_OH  = NUM_STAGES'(1);
  localparam logic [NUM_STAGES-1:0] FETCH_OH = NUM_STAGES'(1) << FETCH_STAGE;
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic [NUM_STAGES-1:0] skip_q, skip_d;
  logic [1:0]            op_q, op_d;
  logic [2:0]            fault_q, fault_d;
  logic                  halted_q, halted_d;
  logic                  dfault_q, dfault_d;
  logic                  trap_q, trap_d;
  logic [CNT_W-1:0]      cyc_q, cyc_d;
  logic [CNT_W-1:0]      ret_q, ret_d;

  logic                  in_ctrl, in_fetch, in_dec, in_wb;
  logic                  done, fault_any;
  logic [2:0]            cause;
  logic [NUM_STAGES-1:0] skip_src;
  logic [NUM_STAGES-1:0] nxt;

  assign in_ctrl   = stage_q[0];
  assign in_fetch  = stage_q[FETCH_STAGE];
  assign in_dec    = stage_q[DECODE_STAGE];
  assign in_wb     = stage_q[NUM_STAGES-1];
  assign done      = |(stage_done & stage_q);
  assign fault_any = (|stage_q) && !in_ctrl && (op_fault || addr_fault || access_fault);
  // Leaving DECODE must already see the mask being captured on that same edge.
  assign skip_src  = in_dec ? stage_skip : skip_q;

  always_comb begin
    cause = 3'd0;
    if (in_fetch) begin
      if (addr_fault)        cause = 3'd0;
      else if (access_fault) cause = 3'd1;
      else                   cause = 3'd2;
    end else begin
      if (op_fault)          cause = 3'd2;
      else if (addr_fault)   cause = is_store ? 3'd6 : 3'd4;
      else                   cause = is_store ? 3'd7 : 3'd5;
    end
  end

  // Lowest later stage not skipped; only stages strictly between DECODE and WRITE_BACK may skip.
  always_comb begin
    int unsigned cur_idx;
    logic        found;
    cur_idx = 0;
    found   = 1'b0;
    nxt     = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (stage_q[i]) cur_idx = i;
    end
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      if (!found && i > cur_idx &&
          !(skip_src[i] && i > DECODE_STAGE && i < NUM_STAGES - 1)) begin
        nxt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    if (in_wb) nxt = CTRL_OH;
  end

  always_comb begin
    stage_d  = stage_q;
    skip_d   = skip_q;
    op_d     = op_q;
    fault_d  = fault_q;
    halted_d = halted_q;
    dfault_d = dfault_q;
    trap_d   = trap_q;
    ret_d    = ret_q;
    cyc_d    = halted_q ? cyc_q : cyc_q + CNT_ONE;
    if (dfault_q) begin
      stage_d = '0;
    end else if (halted_q) begin
      if (!halt_req) begin
        halted_d = 1'b0;
        stage_d  = CTRL_OH;
      end
    end else if (in_ctrl) begin
      if (halt_req) begin
        halted_d = 1'b1;
        stage_d  = '0;
      end else begin
        if (trap_q) begin
          op_d   = OP_TRAP;
          trap_d = 1'b0;
        end else if (ext_int_pending) op_d = OP_EXT;
        else if (sw_int_pending)      op_d = OP_SW;
        else                          op_d = OP_NORM;
        stage_d = FETCH_OH;
      end
    end else if (fault_any) begin
      fault_d = cause;
      if (op_q == OP_NORM) begin
        trap_d  = 1'b1;
        stage_d = CTRL_OH;
      end else begin
        dfault_d = 1'b1;
        halted_d = 1'b1;
        stage_d  = '0;
      end
    end else if (done) begin
      if (in_dec) skip_d = stage_skip;
      if (in_wb && op_q == OP_NORM) ret_d = ret_q + CNT_ONE;
      stage_d = nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q  <= CTRL_OH;
      skip_q   <= '0;
      op_q     <= OP_NORM;
      fault_q  <= '0;
      halted_q <= 1'b0;
      dfault_q <= 1'b0;
      trap_q   <= 1'b0;
      cyc_q    <= '0;
      ret_q    <= '0;
    end else begin
      stage_q  <= stage_d;
      skip_q   <= skip_d;
      op_q     <= op_d;
      fault_q  <= fault_d;
      halted_q <= halted_d;
      dfault_q <= dfault_d;
      trap_q   <= trap_d;
      cyc_q    <= cyc_d;
      ret_q    <= ret_d;
    end
  end

  assign stage_active  = stage_q;
  assign control_op    = op_q;
  assign fault_num     = fault_q;
  assign halted        = halted_q;
  assign double_fault  = dfault_q;
  assign cycle_count   = cyc_q;
  assign retired_count = ret_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: expected per-cycle stage/op/halt pushed to a
// scoreboard queue as stimulus is set up, popped after each clock.
module tb_stage_sequencer;
  localparam int N = 7;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] stage_done, stage_skip;
  logic         op_fault, addr_fault, access_fault, is_store;
  logic         ext_int_pending, sw_int_pending, halt_req;
  logic [N-1:0] stage_active;
  logic [1:0]   control_op;
  logic [2:0]   fault_num;
  logic         halted, double_fault;
  logic [W-1:0] cycle_count, retired_count;

  typedef struct {
    logic [N-1:0] st;
    logic [1:0]   op;
    logic         hlt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  stage_sequencer #(.NUM_STAGES(N), .FETCH_STAGE(1), .DECODE_STAGE(2), .CNT_W(W)) dut (
    .clk(clk), .reset_n(reset_n), .stage_done(stage_done), .stage_skip(stage_skip),
    .op_fault(op_fault), .addr_fault(addr_fault), .access_fault(access_fault),
    .is_store(is_store), .ext_int_pending(ext_int_pending), .sw_int_pending(sw_int_pending),
    .halt_req(halt_req), .stage_active(stage_active), .control_op(control_op),
    .fault_num(fault_num), .halted(halted), .double_fault(double_fault),
    .cycle_count(cycle_count), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // idx < 0 means no stage active
  task automatic push(input int idx, input logic [1:0] op, input logic hlt);
    exp_t e;
    logic [N-1:0] one;
    one = 1;
    e.st  = (idx < 0) ? '0 : (one << idx);
    e.op  = op;
    e.hlt = hlt;
    sb.push_back(e);
  endtask

  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    total++;
    assert (sb.size() > 0) else begin
      bad++;
      $error("FAIL %s: got empty scoreboard want entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "/stage"}, 32'(stage_active), 32'(e.st));
      chk({tag, "/op"}, 32'(control_op), 32'(e.op));
      chk({tag, "/halted"}, 32'(halted), 32'(e.hlt));
    end
  endtask

  task automatic clear_inputs();
    stage_done = '1; stage_skip = '0;
    op_fault = 0; addr_fault = 0; access_fault = 0; is_store = 0;
    ext_int_pending = 0; sw_int_pending = 0; halt_req = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    clear_inputs();
    reset_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst/stage", 32'(stage_active), 32'h1);
    chk("rst/op", 32'(control_op), 32'h3);
    chk("rst/fault", 32'(fault_num), 32'h0);
    chk("rst/halted", 32'(halted), 32'h0);
    chk("rst/dfault", 32'(double_fault), 32'h0);
    chk("rst/cyc", cycle_count, 32'h0);
    chk("rst/ret", retired_count, 32'h0);
    reset_n = 1'b1;

    // full seven-stage instruction
    for (int i = 1; i < N; i++) push(i, 2'b11, 1'b0);
    push(0, 2'b11, 1'b0);
    repeat (7) step("t1");
    chk("t1/ret", retired_count, 32'd1);
    chk("t1/cyc", cycle_count, 32'd7);

    // stages 3 and 5 skipped
    stage_skip = 7'b0101000;
    push(1, 2'b11, 0); push(2, 2'b11, 0); push(4, 2'b11, 0); push(6, 2'b11, 0); push(0, 2'b11, 0);
    repeat (5) step("t2");
    stage_skip = '0;
    chk("t2/ret", retired_count, 32'd2);
    chk("t2/cyc", cycle_count, 32'd12);

    // store access fault in stage 5, then a fault inside the trap sequence
    for (int i = 1; i <= 5; i++) push(i, 2'b11, 0);
    repeat (5) step("t3run");
    access_fault = 1; is_store = 1;
    push(0, 2'b11, 0);
    step("t3fault");
    chk("t3/fault", 32'(fault_num), 32'd7);
    chk("t3/ret", retired_count, 32'd2);
    access_fault = 0; is_store = 0;
    push(1, 2'b00, 0);
    step("t3trap");
    op_fault = 1;
    push(-1, 2'b00, 1);
    step("t3dbl");
    op_fault = 0;
    chk("t3/fault2", 32'(fault_num), 32'd2);
    chk("t3/dfault", 32'(double_fault), 32'd1);
    chk("t3/cyc", cycle_count, 32'd20);
    halt_req = 1;
    push(-1, 2'b00, 1); push(-1, 2'b00, 1);
    repeat (2) step("t3hold");
    halt_req = 0;
    push(-1, 2'b00, 1); push(-1, 2'b00, 1);
    repeat (2) step("t3stuck");
    chk("t3/cyc_frz", cycle_count, 32'd20);
    chk("t3/dfault2", 32'(double_fault), 32'd1);

    // fault priority: op over addr in stage 4, addr over access in FETCH
    do_reset();
    for (int i = 1; i <= 4; i++) push(i, 2'b11, 0);
    repeat (4) step("t4run");
    op_fault = 1; addr_fault = 1;
    push(0, 2'b11, 0);
    step("t4s4");
    chk("t4/fault_s4", 32'(fault_num), 32'd2);
    op_fault = 0; addr_fault = 0;
    push(1, 2'b00, 0);
    step("t4trap");
    addr_fault = 1; access_fault = 1;
    push(-1, 2'b00, 1);
    step("t4fetch");
    chk("t4/fault_fetch", 32'(fault_num), 32'd0);
    chk("t4/dfault", 32'(double_fault), 32'd1);
    chk("t4/ret", retired_count, 32'd0);

    // interrupt priority, no retire during interrupt sequences
    do_reset();
    ext_int_pending = 1; sw_int_pending = 1;
    push(1, 2'b01, 0);
    step("t5ext");
    ext_int_pending = 0;
    for (int i = 2; i < N; i++) push(i, 2'b01, 0);
    push(0, 2'b01, 0);
    repeat (6) step("t5extrun");
    chk("t5/ret_ext", retired_count, 32'd0);
    push(1, 2'b10, 0);
    step("t5sw");
    sw_int_pending = 0;
    for (int i = 2; i < N; i++) push(i, 2'b10, 0);
    push(0, 2'b10, 0);
    repeat (6) step("t5swrun");
    push(1, 2'b11, 0);
    step("t5norm");
    chk("t5/ret_sw", retired_count, 32'd0);

    // debug halt held 10 cycles in CONTROL
    reset_n = 1'b0;
    @(negedge clk);
    clear_inputs();
    halt_req = 1;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) push(-1, 2'b11, 1);
    repeat (10) step("t6halt");
    chk("t6/cyc_frz", cycle_count, 32'd1);
    halt_req = 0;
    push(0, 2'b11, 0);
    step("t6ctrl");
    chk("t6/cyc_rel", cycle_count, 32'd1);
    push(1, 2'b11, 0);
    step("t6fetch");
    chk("t6/cyc_run", cycle_count, 32'd2);
    push(2, 2'b11, 0); push(3, 2'b11, 0); push(4, 2'b11, 0);
    repeat (3) step("t6run");

    // asynchronous reset in the middle of stage 4
    stage_done = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("t7/stage", 32'(stage_active), 32'h1);
    chk("t7/op", 32'(control_op), 32'h3);
    chk("t7/halted", 32'(halted), 32'h0);
    chk("t7/cyc", cycle_count, 32'h0);
    chk("t7/ret", retired_count, 32'h0);
    chk("t7/fault", 32'(fault_num), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    chk("sb/empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
